// File: rtl/pipelined_mul_add.sv
// pipelined_mul_add: valid-tagged p = a*b + addend pipeline.
// The addend is either the external c (mode=0) or an internal accumulator (mode=1, MAC).
// Stage 1 does the full-precision multiply-add. Stages 2..STAGES only delay {valid, ovf, result}.
// Optional feature macro: MUL_ADD_SATURATE_EN. When it is defined, an overflowing result
// clamps to all-ones. When it is undefined (default), the result wraps modulo 2**WIDTH.
// Constraints: WIDTH >= 2, STAGES >= 1.
module pipelined_mul_add #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             in_valid,
    input  logic             mode,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    output logic [WIDTH-1:0] p,
    output logic             ovf
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] addend;
    logic [PW:0]      sum;
    logic             ovf1;
    logic [WIDTH-1:0] r1;

    logic [WIDTH-1:0] acc_d, acc_q;

    // Index k holds the register that feeds stage k+1. Index STAGES drives the outputs.
    logic [STAGES:1]            vld_d, vld_q;
    logic [STAGES:1]            ovf_d, ovf_q;
    logic [STAGES:1][WIDTH-1:0] r_d, r_q;

    // Stage-1 arithmetic: full-width product plus addend, with no intermediate truncation.
    always_comb begin
        prod = PW'(a) * PW'(b);
        if (!mode) begin
            addend = c;
        end else if (acc_clr) begin
            addend = '0;                  // clear-and-accumulate starts from zero
        end else begin
            addend = acc_q;
        end
        sum  = (PW + 1)'(prod) + (PW + 1)'(addend);
        ovf1 = |sum[PW:WIDTH];
`ifdef MUL_ADD_SATURATE_EN
        r1 = ovf1 ? '1 : sum[WIDTH-1:0];
`else
        r1 = sum[WIDTH-1:0];
`endif
    end

    // Accumulator next state: an accumulating beat wins over a bare clear.
    // mode=0 beats never touch the accumulator.
    always_comb begin
        acc_d = acc_q;
        if (in_valid && mode) begin
            acc_d = r1;
        end else if (acc_clr) begin
            acc_d = '0;
        end
    end

    // Pipeline next state: stage 1 takes fresh results; later stages shift.
    // The result register loads even on bubbles, so p is qualified only by out_valid.
    always_comb begin
        vld_d[1] = in_valid;
        ovf_d[1] = ovf1;
        r_d[1]   = r1;
        for (int k = 2; k <= STAGES; k++) begin
            vld_d[k] = vld_q[k-1];
            ovf_d[k] = ovf_q[k-1];
            r_d[k]   = r_q[k-1];
        end
    end

    // All state advances only on enabled edges. Reset discards in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            ovf_q <= '0;
            r_q   <= '0;
            acc_q <= '0;
        end else if (ce) begin
            vld_q <= vld_d;
            ovf_q <= ovf_d;
            r_q   <= r_d;
            acc_q <= acc_d;
        end
    end

    assign out_valid = vld_q[STAGES];
    assign p         = r_q[STAGES];
    assign ovf       = ovf_q[STAGES];

endmodule

// File: tb/tb_pipelined_mul_add.sv
// tb_pipelined_mul_add: three depths (1, 3, 5) driven with identical stimulus.
// The reference model keeps a history of per-enabled-edge results. The expected output
// at depth D is the entry from D enabled edges back.
module tb_pipelined_mul_add;

    logic        clk = 1'b0;
    logic        rst_n, ce, in_valid, mode, acc_clr;
    logic [15:0] a, b, c;
    logic        v1, v3, v5, o1, o3, o5;
    logic [15:0] p1, p3, p5;

    typedef struct packed {
        logic        v;
        logic        o;
        logic [15:0] r;
    } ent_t;

    ent_t        hist[$];
    int unsigned acc_m = 0;
    int          n_pass = 0, n_chk = 0, n_fail = 0;

`ifdef MUL_ADD_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    pipelined_mul_add #(.WIDTH(16), .STAGES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .mode(mode), .acc_clr(acc_clr),
        .a(a), .b(b), .c(c), .out_valid(v1), .p(p1), .ovf(o1));
    pipelined_mul_add #(.WIDTH(16), .STAGES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .mode(mode), .acc_clr(acc_clr),
        .a(a), .b(b), .c(c), .out_valid(v3), .p(p3), .ovf(o3));
    pipelined_mul_add #(.WIDTH(16), .STAGES(5)) u5 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .mode(mode), .acc_clr(acc_clr),
        .a(a), .b(b), .c(c), .out_valid(v5), .p(p5), .ovf(o5));

    always #5 clk = ~clk;

    function automatic ent_t exp_at(int d);
        if (hist.size() >= d) return hist[d-1];
        return '0;
    endfunction

    // One enabled edge of the behavioural model, using the inputs currently applied.
    task automatic model_edge();
        longint unsigned sum;
        longint unsigned addend;
        ent_t            e;
        addend = !mode ? 64'(c) : (acc_clr ? 64'd0 : 64'(acc_m));
        sum    = 64'(a) * 64'(b) + addend;
        e.v    = in_valid;
        e.o    = (sum > 64'd65535);
        e.r    = (SAT && e.o) ? 16'hFFFF : 16'(sum % 65536);
        if (in_valid && mode) acc_m = e.r;
        else if (acc_clr)     acc_m = 0;
        hist.push_front(e);
        if (hist.size() > 8) void'(hist.pop_back());
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_one(string tag, logic v, logic [15:0] pp, logic o, int d);
        ent_t e;
        e = exp_at(d);
        chk({tag, ".valid"}, 32'(v), 32'(e.v));
        if (e.v) begin
            chk({tag, ".p"}, 32'(pp), 32'(e.r));
            chk({tag, ".ovf"}, 32'(o), 32'(e.o));
        end
    endtask

    task automatic check_all();
        check_one("d1", v1, p1, o1, 1);
        check_one("d3", v3, p3, o3, 3);
        check_one("d5", v5, p5, o5, 5);
    endtask

    task automatic step(logic iv, logic md, logic clr, logic [15:0] aa, logic [15:0] bb,
                        logic [15:0] cc, logic en = 1'b1);
        in_valid = iv; mode = md; acc_clr = clr; a = aa; b = bb; c = cc; ce = en;
        @(posedge clk);
        if (en) model_edge();
        #1 check_all();
    endtask

    task automatic idle(int n = 1);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b1; in_valid = 1'b0; mode = 1'b0; acc_clr = 1'b0;
        a = '0; b = '0; c = '0;
        #3;
        chk("rst.v3", 32'(v3), 0);
        chk("rst.p3", 32'(p3), 0);
        chk("rst.ovf3", 32'(o3), 0);
        chk("rst.v1", 32'(v1), 0);
        chk("rst.v5", 32'(v5), 0);
        rst_n = 1'b1;

        // Basic multiply-add: valid for exactly one cycle, three edges after the input.
        step(1, 0, 0, 16'd3, 16'd4, 16'd5);
        chk("basic.early", 32'(v3), 0);
        idle(2);
        chk("basic.v", 32'(v3), 1);
        chk("basic.p", 32'(p3), 17);
        chk("basic.ovf", 32'(o3), 0);
        idle();
        chk("basic.once", 32'(v3), 0);

        // Overflow.
        step(1, 0, 0, 16'hFFFF, 16'd2, 16'd0);
        idle(2);
        chk("ovf.p", 32'(p3), SAT ? 32'hFFFF : 32'hFFFE);
        chk("ovf.flag", 32'(o3), 1);

        // MAC sequence, followed by a mode=0 beat and then an accumulator probe.
        step(1, 1, 1, 16'd2, 16'd3, 16'd0);
        step(1, 1, 0, 16'd2, 16'd3, 16'd0);
        step(1, 1, 0, 16'd2, 16'd3, 16'd0);
        chk("mac.p0", 32'(p3), 6);
        step(1, 0, 0, 16'd1, 16'd1, 16'd1);
        chk("mac.p1", 32'(p3), 12);
        idle();
        chk("mac.p2", 32'(p3), 18);
        idle();
        chk("mac.c", 32'(p3), 2);
        step(1, 1, 0, 16'd0, 16'd0, 16'd0);
        idle(2);
        chk("mac.acc", 32'(p3), 18);

        // Stall: the input offered while ce=0 must be ignored.
        idle(3);
        step(1, 0, 0, 16'd5, 16'd5, 16'd0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 16'd9, 16'd9, 16'd9, 1'b0);
            chk("stall.v", 32'(v3), 0);
        end
        idle();
        chk("stall.wait", 32'(v3), 0);
        idle();
        chk("stall.v3", 32'(v3), 1);
        chk("stall.p", 32'(p3), 25);
        idle();
        chk("stall.ign", 32'(v3), 0);

        // Reset mid-flight.
        step(1, 0, 0, 16'd10, 16'd10, 16'd0);
        step(1, 1, 0, 16'd11, 16'd10, 16'd0);
        step(1, 0, 0, 16'd12, 16'd10, 16'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rmid.v3", 32'(v3), 0);
        chk("rmid.p3", 32'(p3), 0);
        chk("rmid.ovf3", 32'(o3), 0);
        chk("rmid.v5", 32'(v5), 0);
        chk("rmid.p1", 32'(p1), 0);
        hist.delete();
        acc_m = 0;
        #1 rst_n = 1'b1;
        step(1, 1, 0, 16'd1, 16'd1, 16'd0);
        idle(2);
        chk("rmid.v", 32'(v3), 1);
        chk("rmid.acc", 32'(p3), 1);

        // Depth sweep across the STAGES=1 and STAGES=5 instances.
        idle(5);
        step(1, 0, 0, 16'd7, 16'd6, 16'd1);
        chk("d1.v", 32'(v1), 1);
        chk("d1.p", 32'(p1), 43);
        idle(3);
        chk("d5.early", 32'(v5), 0);
        idle();
        chk("d5.v", 32'(v5), 1);
        chk("d5.p", 32'(p5), 43);

        // Randomized traffic checked against the model.
        for (int i = 0; i < 300; i++) begin
            logic [15:0] ra, rb, rc;
            ra = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            rb = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            rc = 16'($urandom);
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 6) == 0), ra, rb, rc, ($urandom_range(0, 4) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipelined_mul_add.md
# pipelined_mul_add

Parametrised, valid-tagged multiply-add pipeline computing `p = a*b + addend`, where the addend is either the external `c` or an internal accumulator. The block supports configurable operand width and pipeline depth, a global clock enable, and overflow reporting. It is the DSP-mapping target for multiply-add and MAC kernels in the lattice-ecp5 and xilinx flows, and generalises the fixed 16-bit three-stage multiply-add.

## Interface
- `WIDTH`, 16, width of operands `a`, `b`, `c` and result `p`; must be at least 2.
- `STAGES`, 3, total register stages from input to `p`; must be at least 1. This equals the latency.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ce` in 1: clock enable. While 0, every register holds, including the accumulator and the valid pipe.
- `in_valid` in 1: input operands are valid this cycle.
- `mode` in 1: 0 selects addend `c`; 1 selects the accumulator (MAC).
- `acc_clr` in 1: zero the accumulator.
- `a`, `b`, `c` in WIDTH: unsigned operands.
- `out_valid` out 1: `p` and `ovf` are valid.
- `p` out WIDTH: result.
- `ovf` out 1: the true result did not fit in WIDTH bits.

## Operation
- Stage 1 samples on an edge with `ce=1`:
  - `prod = a*b`, full 2*WIDTH bits.
  - `addend` is `c` when `mode=0`. When `mode=1`, it is `acc`, or 0 if `acc_clr=1` in the same cycle.
  - `sum = prod + addend`, evaluated at 2*WIDTH+1 bits with no intermediate truncation.
  - `ovf1 = (sum >= 2**WIDTH)`.
  - `r1` is `sum[WIDTH-1:0]` (wrap). `r1` is unaffected by `in_valid`.
  - `v1 = in_valid`.
- Accumulator `acc` (WIDTH bits, internal) updates only on edges with `ce=1`, in priority order:
  - `acc_clr=1` and not (`in_valid` and `mode=1`): `acc <= 0`.
  - `in_valid=1` and `mode=1`: `acc <= r1`. This covers the clear-and-accumulate case, where the addend is 0.
  - Otherwise `acc` holds. `mode=0` transactions never touch `acc`.
- Stages 2..STAGES are plain delay registers for `{v, ovf, r}`. With `STAGES=1`, outputs come straight from stage 1.
- Outputs are the last stage. `p` and `ovf` are meaningful only when `out_valid=1`.
- No backpressure: the block accepts one transaction per enabled cycle, and a downstream consumer must use `ce` to stall.

## Timing
- Reset (`rst_n=0`, asynchronous): `p=0`, `out_valid=0`, `ovf=0`, `acc=0`, and all stage registers are 0 immediately. Any in-flight transactions are discarded.
- Release of `rst_n` is synchronised externally; the first capture is the first rising edge with `rst_n=1` and `ce=1`.
- Latency: a transaction captured at enabled edge E appears on `p` and `out_valid` after the STAGES-th enabled edge counting from E. Disabled edges do not count.
- Throughput: one transaction per enabled cycle. Back-to-back `mode=1` transactions see the accumulator updated by the previous transaction, because the feedback loop has one-cycle latency.
- `ce=0` with `in_valid=1`: the input is ignored and not captured.
- `in_valid=0` cycles insert bubbles that propagate as `out_valid=0`.

## Configuration
- `MUL_ADD_SATURATE_EN` defined:
  - When `ovf1=1`, `r1` is all-ones (2**WIDTH-1) instead of the wrapped value.
  - The accumulator therefore saturates and stays at all-ones until cleared. `ovf` still reports.
- Undefined (default): modular wrap at WIDTH bits, matching the legacy multiply-add semantics. `ovf` still reports.

## Test plan
All cases use WIDTH=16 and STAGES=3 unless stated.
- Basic: `ce=1`, `mode=0`, `a=3`, `b=4`, `c=5`, `in_valid` for one cycle. Required: `p=17`, `ovf=0`, and `out_valid` for exactly one cycle, 3 edges later.
- Overflow: `a=0xFFFF`, `b=2`, `c=0`.
  - Default build: `p=0xFFFE`, `ovf=1`.
  - With `MUL_ADD_SATURATE_EN`: `p=0xFFFF`, `ovf=1`.
- MAC: `mode=1`; first beat has `acc_clr=1`; three consecutive beats of `a=2`, `b=3`. Required: `p` = 6, 12, 18 on consecutive cycles. A following `mode=0` beat with `a=1`, `b=1`, `c=1` gives `p=2` and leaves `acc=18`.
- Stall: capture `a=5`, `b=5`, `c=0`, then hold `ce=0` for 4 cycles. Required: `p` and `out_valid` frozen, an input offered during the stall is ignored, and the result `p=25` arrives on the 3rd enabled edge.
- Reset mid-flight: three beats in flight, then pulse `rst_n=0` between edges. Required: `out_valid`, `p` and `ovf` drop to 0 immediately, none of the in-flight results ever appear, and `acc` reads back 0 via a subsequent `mode=1` beat with `a=1`, `b=1` giving `p=1`.
- Depth sweep: STAGES=1 and STAGES=5 with `a=7`, `b=6`, `c=1`. Required: `p=43` at latency 1 and 5 respectively.
